multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller_pkg.sv | 76 +++++++
 rtl/multicycle_controller_branch_cond.sv | 27 ++
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and the ALU decoder.
// State, opcode and datapath select encodings live here so that every user agrees.
// Helper functions: immediate-format decode and legal branch funct3 check.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  // Immediate format depends only on the opcode; formats without an immediate
  // fall back to I, which the datapath ignores for them.
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_STORE:         sel = IMM_S;
      OP_BRANCH:        sel = IMM_B;
      OP_JAL:           sel = IMM_J;
      OP_LUI, OP_AUIPC: sel = IMM_U;
      default:          sel = IMM_I;
    endcase
    return sel;
  endfunction

  // funct3 010 and 011 are not branch encodings in RV32I.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b010) || (f3 == 3'b011));
  endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch condition evaluator: maps funct3 and ALU subtract flags to taken.
// Purely combinational, zero latency.
// C=1 means no borrow, so unsigned less-than is !C.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       C,
  output logic       taken
);

  // Select the comparison named by funct3; illegal codes never reach BRANCH.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Z;
      3'b001:  taken = !Z;
      3'b100:  taken = N ^ V;
      3'b101:  taken = !(N ^ V);
      3'b110:  taken = !C;
      3'b111:  taken = C;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Per-instruction sequencing FSM for the multi-cycle RV32I datapath.
// Moore outputs from state; mem_ready gates fetch/load writes and access-state advance.
// Reset forces all enables low and selects to their FETCH values in the same cycle.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       C,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [1:0] AluOp,
  output logic       retire,
  output logic       trap
);

  state_t state;
  state_t state_nxt;
  logic   taken;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .Z      (Z),
    .N      (N),
    .V      (V),
    .C      (C),
    .taken  (taken)
  );

  assign ImmSrc = imm_src(opcode);

  // Single state register; ILLEGAL is left only through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode, with reset overriding outputs last.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    AluOp     = ALUOP_ADD;
    retire    = 1'b0;
    trap      = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_REG:            state_nxt = S_EXECR;
          OP_IMM:            state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = branch_f3_legal(funct3) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        AluOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        AluOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        AluOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = taken;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // PC <- target held in ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_JAL;
      end
      S_LUI: begin
        ALUSrcB   = SRCB_IMM;
        AluOp     = ALUOP_PASSB;
        state_nxt = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_ALUWB;
      end
      S_ILLEGAL: begin
        trap = 1'b1;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    if (reset) begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      retire    = 1'b0;
      trap      = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALU;
      AluOp     = ALUOP_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// trace (with random memory waits and flags) and replayed against the DUT.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       Z, N, V, C;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, AluOp;
  logic [2:0] ImmSrc;
  logic       retire, trap;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .Z         (Z),
    .N         (N),
    .V         (V),
    .C         (C),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .AluOp     (AluOp),
    .retire    (retire),
    .trap      (trap)
  );

  // One expected cycle: stimulus plus required outputs (-1 = not checked).
  typedef struct {
    logic       rdy;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] flags;
    int req, mw, adr, ir, pcw, rw, ret, trp, a, b, rs, aop;
  } cyc_t;

  cyc_t       q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       use_fl;
  logic [3:0] fl;
  int errors = 0;
  int checks = 0;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imm_exp(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 0;
      7'b0100011:                         return 1;
      7'b1100011:                         return 2;
      7'b1101111:                         return 3;
      7'b0110111, 7'b0010111:             return 4;
      default:                            return -1;
    endcase
  endfunction

  task automatic push(input int rdy, input int req, mw, adr, ir, pcw, rw, ret, trp,
                      input int a, b, rs, aop);
    cyc_t r;
    r.rdy   = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
    r.op    = cur_op;
    r.f3    = cur_f3;
    r.flags = use_fl ? fl : 4'($urandom);
    r.req = req; r.mw = mw; r.adr = adr; r.ir = ir; r.pcw = pcw; r.rw = rw;
    r.ret = ret; r.trp = trp; r.a = a; r.b = b; r.rs = rs; r.aop = aop;
    q.push_back(r);
  endtask

  task automatic aluwb();
    push(-1, 0, 0, -1, 0, 0, 1, 1, 0, -1, -1, 0, -1);
  endtask

  task automatic jal_step();
    push(-1, 0, 0, -1, 0, 1, 0, 0, 0, 1, 2, 0, 0);
  endtask

  task automatic illegal(input int n);
    for (int i = 0; i < n; i++) push(-1, 0, 0, -1, 0, 0, 0, 0, 1, -1, -1, -1, -1);
  endtask

  // Expand the current instruction into its expected cycle trace.
  task automatic gen(input int fw, input int mwait, input logic [31:0] a,
                     input logic [31:0] b, input int ill_len);
    logic [31:0] d;
    logic        tk;
    for (int i = 0; i < fw; i++) push(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    push(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0);
    push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 1, 1, -1, 0);
    case (cur_op)
      7'b0110011: begin push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 2, 0, -1, 2); aluwb(); end
      7'b0010011: begin push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 2, 1, -1, 2); aluwb(); end
      7'b0000011: begin
        push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 2, 1, -1, 0);
        for (int i = 0; i < mwait; i++) push(0, 1, 0, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1);
        push(1, 1, 0, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1);
        push(1, 0, 0, -1, 0, 0, 1, 1, 0, -1, -1, 1, -1);
      end
      7'b0100011: begin
        push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 2, 1, -1, 0);
        for (int i = 0; i < mwait; i++) push(0, 1, 1, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1);
        push(1, 1, 1, 1, 0, 0, 0, 1, 0, -1, -1, -1, -1);
      end
      7'b1100011: begin
        if (cur_f3 == 3'b010 || cur_f3 == 3'b011) begin
          illegal(ill_len);
        end else begin
          d  = a - b;
          fl = {d == 32'd0, d[31], (a[31] != b[31]) && (d[31] != a[31]), a >= b};
          case (cur_f3)
            3'b000:  tk = (a == b);
            3'b001:  tk = (a != b);
            3'b100:  tk = ($signed(a) < $signed(b));
            3'b101:  tk = ($signed(a) >= $signed(b));
            3'b110:  tk = (a < b);
            default: tk = (a >= b);
          endcase
          use_fl = 1'b1;
          push(-1, 0, 0, -1, 0, int'(tk), 0, 1, 0, 2, 0, 0, 1);
          use_fl = 1'b0;
        end
      end
      7'b1101111: begin jal_step(); aluwb(); end
      7'b1100111: begin push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 2, 1, -1, 0); jal_step(); aluwb(); end
      7'b0110111: begin push(-1, 0, 0, -1, 0, 0, 0, 0, 0, -1, 1, -1, 3); aluwb(); end
      7'b0010111: begin push(-1, 0, 0, -1, 0, 0, 0, 0, 0, 1, 1, -1, 0); aluwb(); end
      default:    illegal(ill_len);
    endcase
  endtask

  task automatic do_cycle(input cyc_t r);
    reset = 1'b0; opcode = r.op; funct3 = r.f3; {Z, N, V, C} = r.flags; mem_ready = r.rdy;
    @(negedge clk);
    chk("mem_req", 32'(mem_req), r.req);
    chk("MemWrite", 32'(MemWrite), r.mw);
    chk("IRWrite", 32'(IRWrite), r.ir);
    chk("PCWrite", 32'(PCWrite), r.pcw);
    chk("RegWrite", 32'(RegWrite), r.rw);
    chk("retire", 32'(retire), r.ret);
    chk("trap", 32'(trap), r.trp);
    if (r.adr >= 0) chk("AdrSrc", 32'(AdrSrc), r.adr);
    if (r.a >= 0)   chk("ALUSrcA", 32'(ALUSrcA), r.a);
    if (r.b >= 0)   chk("ALUSrcB", 32'(ALUSrcB), r.b);
    if (r.rs >= 0)  chk("ResultSrc", 32'(ResultSrc), r.rs);
    if (r.aop >= 0) chk("AluOp", 32'(AluOp), r.aop);
    if (imm_exp(r.op) >= 0) chk("ImmSrc", 32'(ImmSrc), imm_exp(r.op));
    @(posedge clk); #1;
  endtask

  // Replay up to n queued cycles (n < 0: all of them).
  task automatic run(input int n);
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      do_cycle(q.pop_front());
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'($urandom_range(0, 1)); {Z, N, V, C} = 4'($urandom);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_MemWrite", 32'(MemWrite), 0);
    chk("rst_IRWrite", 32'(IRWrite), 0);
    chk("rst_PCWrite", 32'(PCWrite), 0);
    chk("rst_RegWrite", 32'(RegWrite), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_AdrSrc", 32'(AdrSrc), 0);
    chk("rst_ALUSrcA", 32'(ALUSrcA), 0);
    chk("rst_ALUSrcB", 32'(ALUSrcB), 2);
    chk("rst_ResultSrc", 32'(ResultSrc), 2);
    chk("rst_AluOp", 32'(AluOp), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic one(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mwait,
                     input logic [31:0] a, input logic [31:0] b, input int ill_len);
    cur_op = op; cur_f3 = f3;
    gen(fw, mwait, a, b, ill_len);
    run(-1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic [6:0]  op;
    use_fl = 1'b0; fl = 4'd0; cur_op = 7'd0; cur_f3 = 3'd0;
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; {Z, N, V, C} = 4'd0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    one(7'b0110011, 3'b000, 0, 0, 0, 0, 0);                        // add
    one(7'b0000011, 3'b010, 0, 2, 0, 0, 0);                        // lw, 2 waits
    one(7'b1100011, 3'b100, 0, 0, 32'hffffffff, 32'h0, 0);         // blt taken
    one(7'b1100011, 3'b100, 0, 0, 32'h7fffffff, 32'hffffffff, 0);  // blt not taken
    one(7'b1100111, 3'b000, 0, 0, 0, 0, 0);                        // jalr

    for (int i = 0; i < 120; i++) begin
      op = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom);
      if (op == 7'b1100011 && (f3 == 3'b010 || f3 == 3'b011)) f3 = 3'b000;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      one(op, f3, $urandom_range(0, 2), $urandom_range(0, 2), a, b, 0);
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    // Reset while a store is waiting on memory: the access is abandoned.
    cur_op = 7'b0100011; cur_f3 = 3'b010;
    gen(0, 6, 0, 0, 0);
    run(5);
    do_reset();
    q.delete();
    // Reset while a fetch is waiting.
    cur_op = 7'b0110011;
    gen(3, 0, 0, 0, 0);
    run(2);
    do_reset();
    q.delete();
    one(7'b0110011, 3'b000, 1, 0, 0, 0, 0);

    // Illegal opcode: trap sticky, no memory requests, cleared by reset.
    one(7'b1111111, 3'b000, 0, 0, 0, 0, 20);
    do_reset();
    one(7'b0010011, 3'b000, 0, 0, 0, 0, 0);
    // Branch with a non-branch funct3 is also illegal.
    one(7'b1100011, 3'b011, 0, 0, 0, 0, 6);
    do_reset();
    one(7'b1100011, 3'b010, 1, 0, 0, 0, 4);
    do_reset();
    one(7'b0110111, 3'b000, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
